hazard_unit: RTL and testbench

Pipeline hazard controller sitting on the read side of the ID/EX register. It compares the ID-stage source registers against the destinations of the EX, MEM and WB stages and produces forwarding selects for the A and RB operands. It detects load-use hazards, nullifies the PA-RISC delay-slot instruction when an EX-stage branch requests it (N bit), and holds the whole pipeline while data RAM is busy. A nullify request that arrives during a RAM freeze is kept until the freeze ends.

---
 rtl/hazard_unit_pkg.sv | 16 +
 rtl/hazard_unit_if.sv | 22 ++
 rtl/hazard_unit_fwd_sel.sv | 38 +++
 rtl/hazard_unit.sv | 107 ++++++++++
 tb/tb_hazard_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: forwarding select encodings, hazard FSM states
// and the register-number width.
package hazard_unit_pkg;
  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    FREEZE    = 2'd1,
    NULL_PEND = 2'd2
  } haz_state_e;
endpackage

// File: rtl/hazard_unit_if.sv
// Hazard unit bus: ID/EX/MEM/WB register info in, forwarding selects and
// pipeline enables out. master = pipeline side, slave = hazard unit.
interface hazard_unit_if #(parameter int REG_W = hazard_unit_pkg::REG_W);
  logic [REG_W-1:0] ID_RA, ID_RB, EX_RD, MEM_RD, WB_RD;
  logic             ID_USE_A, ID_USE_B;
  logic             EX_RF_LE, EX_L, MEM_RF_LE, WB_RF_LE;
  logic             EX_NULL_REQ, MEM_WAIT;
  logic [1:0]       FWD_A, FWD_B;
  logic             PC_LE, IF_ID_LE, ID_EX_LE, CU_NOP;

  modport master (
    output ID_RA, ID_RB, ID_USE_A, ID_USE_B, EX_RD, EX_RF_LE, EX_L,
           MEM_RD, MEM_RF_LE, WB_RD, WB_RF_LE, EX_NULL_REQ, MEM_WAIT,
    input  FWD_A, FWD_B, PC_LE, IF_ID_LE, ID_EX_LE, CU_NOP
  );

  modport slave (
    input  ID_RA, ID_RB, ID_USE_A, ID_USE_B, EX_RD, EX_RF_LE, EX_L,
           MEM_RD, MEM_RF_LE, WB_RD, WB_RF_LE, EX_NULL_REQ, MEM_WAIT,
    output FWD_A, FWD_B, PC_LE, IF_ID_LE, ID_EX_LE, CU_NOP
  );
endinterface

// File: rtl/hazard_unit_fwd_sel.sv
// One operand's forwarding comparator: EX > MEM > WB priority; an EX load
// match raises lu instead of forwarding.
module fwd_sel
  import hazard_unit_pkg::*;
#(
  parameter int REG_W = hazard_unit_pkg::REG_W
) (
  input  logic [REG_W-1:0] id_r,
  input  logic             id_use,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_le,
  input  logic             ex_l,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_le,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_le,
  output logic [1:0]       sel,
  output logic             lu
);
  // GR0 reads as zero, so it never needs a bypass
  logic active;
  assign active = id_use && (id_r != '0);

  always_comb begin
    sel = FWD_RF;
    lu  = 1'b0;
    if (active) begin
      if (ex_le && ex_rd == id_r) begin
        if (ex_l) lu  = 1'b1;
        else      sel = FWD_EX;
      end else if (mem_le && mem_rd == id_r) begin
        sel = FWD_MEM;
      end else if (wb_le && wb_rd == id_r) begin
        sel = FWD_WB;
      end
    end
  end
endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding, load-use bubble, delay-slot
// nullify and RAM freeze. Optional counters under `HAZ_STATS_EN.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_W = hazard_unit_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             Reset,
  hazard_unit_if.slave     bus
`ifdef HAZ_STATS_EN
  ,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] NULL_CNT
`endif
);
  logic [1:0] sel_a, sel_b;
  logic       lu_a, lu_b, lu;
  haz_state_e state, state_nxt;
  logic       null_evt;
  logic       pc_le, if_id_le, id_ex_le, cu_nop;

  fwd_sel #(.REG_W(REG_W)) u_fwd_a (
    .id_r(bus.ID_RA), .id_use(bus.ID_USE_A),
    .ex_rd(bus.EX_RD), .ex_le(bus.EX_RF_LE), .ex_l(bus.EX_L),
    .mem_rd(bus.MEM_RD), .mem_le(bus.MEM_RF_LE),
    .wb_rd(bus.WB_RD), .wb_le(bus.WB_RF_LE),
    .sel(sel_a), .lu(lu_a)
  );

  fwd_sel #(.REG_W(REG_W)) u_fwd_b (
    .id_r(bus.ID_RB), .id_use(bus.ID_USE_B),
    .ex_rd(bus.EX_RD), .ex_le(bus.EX_RF_LE), .ex_l(bus.EX_L),
    .mem_rd(bus.MEM_RD), .mem_le(bus.MEM_RF_LE),
    .wb_rd(bus.WB_RD), .wb_le(bus.WB_RF_LE),
    .sel(sel_b), .lu(lu_b)
  );

  assign lu = lu_a | lu_b;

  // FREEZE with MEM_WAIT low behaves exactly like RUN, so they share a branch
  always_comb begin
    state_nxt = state;
    pc_le     = 1'b1;
    if_id_le  = 1'b1;
    id_ex_le  = 1'b1;
    cu_nop    = 1'b0;
    null_evt  = 1'b0;
    if (Reset) begin
      cu_nop    = 1'b1;
      state_nxt = RUN;
    end else if (state == NULL_PEND) begin
      if (bus.MEM_WAIT) begin
        {pc_le, if_id_le, id_ex_le} = 3'b000;
      end else begin
        cu_nop    = 1'b1;
        null_evt  = 1'b1;
        state_nxt = RUN;
      end
    end else begin
      if (bus.MEM_WAIT) begin
        {pc_le, if_id_le, id_ex_le} = 3'b000;
        state_nxt = bus.EX_NULL_REQ ? NULL_PEND : FREEZE;
      end else if (bus.EX_NULL_REQ) begin
        cu_nop    = 1'b1;
        null_evt  = 1'b1;
        state_nxt = RUN;
      end else if (lu) begin
        pc_le     = 1'b0;
        if_id_le  = 1'b0;
        cu_nop    = 1'b1;
        state_nxt = RUN;
      end else begin
        state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) state <= RUN;
    else       state <= state_nxt;
  end

  assign bus.FWD_A    = Reset ? FWD_RF : sel_a;
  assign bus.FWD_B    = Reset ? FWD_RF : sel_b;
  assign bus.PC_LE    = pc_le;
  assign bus.IF_ID_LE = if_id_le;
  assign bus.ID_EX_LE = id_ex_le;
  assign bus.CU_NOP   = cu_nop;

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk) begin
    if (Reset) begin
      STALL_CNT <= '0;
      NULL_CNT  <= '0;
    end else begin
      if (!pc_le)   STALL_CNT <= STALL_CNT + 1'b1;
      if (null_evt) NULL_CNT  <= NULL_CNT + 1'b1;
    end
  end
`else
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_unit: CNT_W must be at least 1");
  end
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; counter checks run only when
// built with HAZ_STATS_EN.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  hazard_unit_if #(.REG_W(5)) bus();

`ifdef HAZ_STATS_EN
  logic [3:0] stall_cnt, null_cnt;
`endif

  hazard_unit #(.REG_W(5), .CNT_W(4)) dut (
    .clk(clk),
    .Reset(Reset),
    .bus(bus)
`ifdef HAZ_STATS_EN
    ,
    .STALL_CNT(stall_cnt),
    .NULL_CNT(null_cnt)
`endif
  );

  // {PC_LE, IF_ID_LE, ID_EX_LE, CU_NOP}
  logic [3:0] ctl;
  assign ctl = {bus.PC_LE, bus.IF_ID_LE, bus.ID_EX_LE, bus.CU_NOP};

  task automatic idle();
    bus.ID_RA = '0; bus.ID_RB = '0; bus.ID_USE_A = 1'b0; bus.ID_USE_B = 1'b0;
    bus.EX_RD = '0; bus.EX_RF_LE = 1'b0; bus.EX_L = 1'b0;
    bus.MEM_RD = '0; bus.MEM_RF_LE = 1'b0;
    bus.WB_RD = '0; bus.WB_RF_LE = 1'b0;
    bus.EX_NULL_REQ = 1'b0; bus.MEM_WAIT = 1'b0;
  endtask

  task automatic set_lu_b();
    bus.EX_L = 1'b1; bus.EX_RD = 5'd7; bus.EX_RF_LE = 1'b1;
    bus.ID_RB = 5'd7; bus.ID_USE_B = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    Reset = 1'b1; idle();
    bus.EX_RD = 5'd5; bus.EX_RF_LE = 1'b1; bus.ID_RA = 5'd5; bus.ID_USE_A = 1'b1;
    #1;
    total++; if (bus.FWD_A !== 2'b00) begin bad++; $display("FAIL reset_fwd_a got=%b exp=00", bus.FWD_A); end
    total++; if (ctl !== 4'b1111) begin bad++; $display("FAIL reset_ctl got=%b exp=1111", ctl); end
    @(negedge clk);
    Reset = 1'b0; idle(); #1;
    total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL post_reset_ctl got=%b exp=1110", ctl); end
`ifdef HAZ_STATS_EN
    total++; if (stall_cnt !== 4'd0 || null_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, null_cnt); end
`endif
  endtask

  task automatic test_forwarding();
    @(negedge clk); idle();
    bus.EX_RD = 5'd5; bus.EX_RF_LE = 1'b1; bus.ID_RA = 5'd5; bus.ID_USE_A = 1'b1; #1;
    total++; if (bus.FWD_A !== 2'b01) begin bad++; $display("FAIL fwd_ex got=%b exp=01", bus.FWD_A); end
    @(negedge clk); bus.MEM_RD = 5'd5; bus.MEM_RF_LE = 1'b1; #1;
    total++; if (bus.FWD_A !== 2'b01) begin bad++; $display("FAIL fwd_ex_over_mem got=%b exp=01", bus.FWD_A); end
    @(negedge clk); bus.ID_RA = 5'd0; bus.EX_RD = 5'd0; bus.MEM_RD = 5'd0; #1;
    total++; if (bus.FWD_A !== 2'b00) begin bad++; $display("FAIL fwd_gr0 got=%b exp=00", bus.FWD_A); end
    @(negedge clk); bus.ID_RA = 5'd5; bus.EX_RD = 5'd5; bus.EX_RF_LE = 1'b0; bus.MEM_RD = 5'd5; #1;
    total++; if (bus.FWD_A !== 2'b10) begin bad++; $display("FAIL fwd_mem got=%b exp=10", bus.FWD_A); end
    @(negedge clk); bus.MEM_RF_LE = 1'b0; bus.WB_RD = 5'd5; bus.WB_RF_LE = 1'b1; #1;
    total++; if (bus.FWD_A !== 2'b11) begin bad++; $display("FAIL fwd_wb got=%b exp=11", bus.FWD_A); end
    @(negedge clk); bus.ID_USE_A = 1'b0; #1;
    total++; if (bus.FWD_A !== 2'b00) begin bad++; $display("FAIL fwd_unused got=%b exp=00", bus.FWD_A); end
    @(negedge clk); idle();
    bus.ID_RB = 5'd9; bus.ID_USE_B = 1'b1; bus.EX_RD = 5'd9;
    bus.MEM_RD = 5'd9; bus.MEM_RF_LE = 1'b1; bus.WB_RD = 5'd9; bus.WB_RF_LE = 1'b1; #1;
    total++; if (bus.FWD_B !== 2'b10) begin bad++; $display("FAIL fwd_b_mem_over_wb got=%b exp=10", bus.FWD_B); end
    total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL fwd_no_stall got=%b exp=1110", ctl); end
  endtask

  task automatic test_load_use();
    @(negedge clk); idle(); set_lu_b(); #1;
    total++; if (ctl !== 4'b0011) begin bad++; $display("FAIL lu_bubble got=%b exp=0011", ctl); end
    @(negedge clk); idle();
    bus.ID_RB = 5'd7; bus.ID_USE_B = 1'b1; bus.MEM_RD = 5'd7; bus.MEM_RF_LE = 1'b1; #1;
    total++; if (bus.FWD_B !== 2'b10) begin bad++; $display("FAIL lu_next_fwd got=%b exp=10", bus.FWD_B); end
    total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL lu_next_ctl got=%b exp=1110", ctl); end
  endtask

  task automatic test_lu_nullify();
    @(negedge clk); idle(); set_lu_b(); bus.EX_NULL_REQ = 1'b1; #1;
    total++; if (ctl !== 4'b1111) begin bad++; $display("FAIL lu_null got=%b exp=1111", ctl); end
    @(negedge clk); idle(); #1;
    total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL lu_null_after got=%b exp=1110", ctl); end
  endtask

  task automatic test_freeze_nullify();
    @(negedge clk); idle(); bus.MEM_WAIT = 1'b1; bus.EX_NULL_REQ = 1'b1; #1;
    total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL frz_null_c1 got=%b exp=0000", ctl); end
    for (int i = 2; i <= 3; i++) begin
      @(negedge clk); bus.EX_NULL_REQ = 1'b0; bus.MEM_WAIT = 1'b1; #1;
      total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL frz_null_c%0d got=%b exp=0000", i, ctl); end
    end
    @(negedge clk); bus.MEM_WAIT = 1'b0; #1;
    total++; if (ctl !== 4'b1111) begin bad++; $display("FAIL frz_null_release got=%b exp=1111", ctl); end
    @(negedge clk); #1;
    total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL frz_null_once got=%b exp=1110", ctl); end
  endtask

  task automatic test_freeze_lu();
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk); idle(); set_lu_b(); bus.MEM_WAIT = 1'b1; #1;
      total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL frz_lu_c%0d got=%b exp=0000", i, ctl); end
    end
    @(negedge clk); bus.MEM_WAIT = 1'b0; #1;
    total++; if (ctl !== 4'b0011) begin bad++; $display("FAIL frz_lu_release got=%b exp=0011", ctl); end
    @(negedge clk); idle(); #1;
    total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL frz_lu_after got=%b exp=1110", ctl); end
  endtask

  task automatic test_reset_pending();
    @(negedge clk); idle(); bus.MEM_WAIT = 1'b1; bus.EX_NULL_REQ = 1'b1; #1;
    total++; if (ctl !== 4'b0000) begin bad++; $display("FAIL rstp_pend got=%b exp=0000", ctl); end
    @(negedge clk); Reset = 1'b1; bus.EX_NULL_REQ = 1'b0; #1;
    total++; if (ctl !== 4'b1111) begin bad++; $display("FAIL rstp_reset got=%b exp=1111", ctl); end
    @(negedge clk); Reset = 1'b0; idle(); #1;
    total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL rstp_no_null got=%b exp=1110", ctl); end
`ifdef HAZ_STATS_EN
    total++; if (stall_cnt !== 4'd0 || null_cnt !== 4'd0) begin bad++; $display("FAIL rstp_cnt got=%0d/%0d exp=0/0", stall_cnt, null_cnt); end
`endif
  endtask

`ifdef HAZ_STATS_EN
  task automatic test_stats();
    @(negedge clk); Reset = 1'b1; idle();
    @(negedge clk); Reset = 1'b0; set_lu_b();
    repeat (15) @(negedge clk);
    #1;
    total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL stall_cnt_15 got=%0d exp=15", stall_cnt); end
    @(negedge clk); #1;
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL stall_cnt_wrap got=%0d exp=0", stall_cnt); end
    idle(); bus.EX_NULL_REQ = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (null_cnt !== 4'd3) begin bad++; $display("FAIL null_cnt_run got=%0d exp=3", null_cnt); end
    bus.MEM_WAIT = 1'b1;
    @(negedge clk); bus.MEM_WAIT = 1'b0; bus.EX_NULL_REQ = 1'b0;
    @(negedge clk); #1;
    total++; if (null_cnt !== 4'd4) begin bad++; $display("FAIL null_cnt_pend got=%0d exp=4", null_cnt); end
    total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL stall_cnt_frz got=%0d exp=1", stall_cnt); end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_lu_nullify();
    test_freeze_nullify();
    test_freeze_lu();
    test_reset_pending();
`ifdef HAZ_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
